unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Shares one single-port, 1-cycle-latency SRAM between the CPU instruction-fetch port and data-memory port, so the core can run from a unified memory. Sits between the CPU's im_*/dm_* pins and the SRAM macro. Grants at most one access per cycle, returns read data one cycle after grant, and produces the stall that freezes the pipeline while a port waits. Data port has priority; an optional aging counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 14, word address width
- DATA_W, 32, data width; bweb width = DATA_W
- MAX_WAIT, 4, consecutive denied IM cycles before IM wins a tie; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- im_req  in  1  fetch request
- im_addr  in  ADDR_W  fetch address
- im_gnt  out  1  fetch accepted this cycle
- im_rvalid  out  1  im_rdata valid
- im_rdata  out  DATA_W  fetched instruction, held until next im_rvalid
- dm_req  in  1  data request
- dm_web  in  1  0 = write, 1 = read
- dm_bweb  in  DATA_W  active-low bit write mask
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data access accepted this cycle
- dm_rvalid  out  1  read data valid / write acknowledged
- dm_rdata  out  DATA_W  load data, held until next dm_rvalid read
- cpu_stall  out  1  (im_req & ~im_gnt) | (dm_req & ~dm_gnt)
- sram_ceb  out  1  active-low chip enable
- sram_web  out  1  active-low write enable
- sram_bweb  out  DATA_W  active-low bit mask
- sram_addr  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data, valid cycle after ceb low

## Operation
- Requester holds req and payload stable until its gnt; gnt is combinational from req and arbiter state.
- Winner: DM when dm_req, unless ARB_FAIRNESS_EN and wait_cnt == MAX_WAIT and im_req, then IM. Otherwise IM if im_req. No request: sram_ceb=1, web=1, bweb all ones, addr/di 0.
- SRAM outputs driven combinationally from the winner; IM grant always read (web=1, bweb all ones).
- Response FSM (register resp_q): R_NONE, R_IM, R_DM_RD, R_DM_WR = owner of previous cycle's grant. Next state = current grant owner/type, R_NONE if none. New grant allowed in any state (fully pipelined).
- R_IM: im_rvalid=1, im_rdata<=sram_do. R_DM_RD: dm_rvalid=1, dm_rdata<=sram_do. R_DM_WR: dm_rvalid=1, dm_rdata unchanged.
- wait_cnt (4 bits): +1 when im_req & ~im_gnt, saturating at MAX_WAIT; cleared on im_gnt or ~im_req.
- Write with bweb all ones: still granted and acknowledged; memory unchanged.

## Timing
- Reset (rst low, any time, asynchronous): resp_q=R_NONE, wait_cnt=0, im_rvalid=dm_rvalid=0, im_rdata=dm_rdata=0; SRAM outputs forced idle (ceb=1, web=1, bweb all ones) while rst low; gnts 0; cpu_stall 0. Read in flight is dropped, no rvalid.
- Grant cycle N -> rvalid cycle N+1 (rvalid registered, rdata registered from sram_do at end of N+1, visible N+1 via bypass: rdata = sram_do when rvalid, else held register).
- Simultaneous im_req & dm_req: one granted, other sees gnt=0, cpu_stall=1 that cycle.
- Back-to-back grants each cycle to alternating owners: both rvalids each exactly one cycle after their grant; throughput 1 access/cycle.

## Configuration
- ARB_FAIRNESS_EN defined: wait_cnt instantiated; IM wins at wait_cnt == MAX_WAIT.
- Undefined: strict DM priority, no counter; IM can starve under continuous dm_req.

## Structure
- Package mem_arb_pkg: resp_e enum (R_NONE, R_IM, R_DM_RD, R_DM_WR), ADDR_W/DATA_W defaults, SRAM idle constants.
- Sub-module arb_age_counter: saturating wait counter with inc/clr/sat, compiled only under ARB_FAIRNESS_EN.

## Test plan
- Reset: rst low mid-read of 0x0010 -> no rvalid, sram_ceb=1, all outputs at reset values.
- IM only: im_req addr 0x0004 with mem=0x00A00093 -> im_gnt same cycle, im_rvalid next cycle, im_rdata=0x00A00093.
- Conflict: im_req and dm_req read 0x0100 together -> dm_gnt=1, im_gnt=0, cpu_stall=1; IM granted next cycle.
- Write then read: dm write 0x0020 data 0xDEADBEEF bweb 0x0000FFFF, then read -> dm_rdata 0xDEAD0000 over prior 0x00000000, write ack dm_rvalid=1.
- Fairness (ARB_FAIRNESS_EN, MAX_WAIT=4): continuous dm_req and im_req -> IM granted on 5th cycle; without macro IM never granted over 20 cycles.
- Pipelined alternation: DM read, IM read, DM read in consecutive cycles -> three rvalids on consecutive cycles, correct port and data each.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data SRAM arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 32;

    // Owner of the previous cycle's grant, i.e. who the current sram_do belongs to
    typedef enum logic [1:0] {
        R_NONE,
        R_IM,
        R_DM_RD,
        R_DM_WR
    } resp_e;

    localparam logic SRAM_CEB_IDLE = 1'b1;
    localparam logic SRAM_WEB_IDLE = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// CPU-side fetch/data port bundle; the CPU is the master, the arbiter the slave.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;

    logic              dm_req;
    logic              dm_web;
    logic [DATA_W-1:0] dm_bweb;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              cpu_stall;

    modport master (
        output im_req, im_addr,
        input  im_gnt, im_rvalid, im_rdata,
        output dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  cpu_stall
    );

    modport slave (
        input  im_req, im_addr,
        output im_gnt, im_rvalid, im_rdata,
        input  dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output cpu_stall
    );
endinterface

// File: rtl/unified_mem_arbiter_age_counter.sv
// Saturating count of consecutive cycles the fetch port was denied.
module arb_age_counter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign sat = (cnt == 4'(MAX_WAIT));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM arbiter for fetch and data ports, DM priority, 1-cycle read latency.
// Define ARB_FAIRNESS_EN to let a starved fetch win after MAX_WAIT denied cycles.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    unified_mem_arbiter_if.slave cpu,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);
    logic              im_win;
    logic              im_gnt;
    logic              dm_gnt;
    resp_e             resp_q;
    resp_e             resp_d;
    logic [DATA_W-1:0] im_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

`ifdef ARB_FAIRNESS_EN
    logic age_sat;

    arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk (clk),
        .rst (rst),
        .inc (cpu.im_req & ~im_gnt),
        .clr (~cpu.im_req | im_gnt),
        .sat (age_sat)
    );

    assign im_win = cpu.im_req & (~cpu.dm_req | age_sat);
`else
    assign im_win = cpu.im_req & ~cpu.dm_req;
`endif

    // Grants and stall are gated by rst so everything reads idle during reset
    assign im_gnt        = rst & im_win;
    assign dm_gnt        = rst & cpu.dm_req & ~im_win;
    assign cpu.im_gnt    = im_gnt;
    assign cpu.dm_gnt    = dm_gnt;
    assign cpu.cpu_stall = rst & ((cpu.im_req & ~im_gnt) | (cpu.dm_req & ~dm_gnt));

    always_comb begin
        sram_ceb  = SRAM_CEB_IDLE;
        sram_web  = SRAM_WEB_IDLE;
        sram_bweb = '1;
        sram_addr = '0;
        sram_di   = '0;
        if (dm_gnt) begin
            sram_ceb  = 1'b0;
            sram_web  = cpu.dm_web;
            sram_bweb = cpu.dm_bweb;
            sram_addr = cpu.dm_addr;
            sram_di   = cpu.dm_wdata;
        end else if (im_gnt) begin
            sram_ceb  = 1'b0;
            sram_addr = cpu.im_addr;
        end
    end

    always_comb begin
        resp_d = R_NONE;
        if (dm_gnt) begin
            resp_d = cpu.dm_web ? R_DM_RD : R_DM_WR;
        end else if (im_gnt) begin
            resp_d = R_IM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_q     <= R_NONE;
            im_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            resp_q <= resp_d;
            if (resp_q == R_IM) begin
                im_rdata_q <= sram_do;
            end
            if (resp_q == R_DM_RD) begin
                dm_rdata_q <= sram_do;
            end
        end
    end

    // Read data bypasses sram_do in the rvalid cycle, then holds the captured copy
    assign cpu.im_rvalid = (resp_q == R_IM);
    assign cpu.dm_rvalid = (resp_q == R_DM_RD) || (resp_q == R_DM_WR);
    assign cpu.im_rdata  = (resp_q == R_IM) ? sram_do : im_rdata_q;
    assign cpu.dm_rdata  = (resp_q == R_DM_RD) ? sram_do : dm_rdata_q;
endmodule
